pipe_hazard_ctrl: RTL

Central hazard and pipeline-control unit for the 5-stage RV32 core (IF/ID/EX/MEM/WB). It drives every `dp_reg` stage register and the PC register. It generates operand-forwarding selects for `NRS` EX-stage source operands, load-use and non-ALU-result stalls, branch/jump flushes, and a fixed-latency data-memory wait sequence that freezes the whole pipeline. A saturating stall-cycle counter is provided for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and pipeline-control unit for the 5-stage RV32 core.
//               Produces EX operand-forwarding selects, load-use and
//               non-ALU-result stalls, branch/jump flushes, a fixed-latency
//               data-memory wait sequence, and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int AW      = 5,
    parameter int NRS     = 2,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRS*AW-1:0]    rs_IfId,
    input  logic [NRS*AW-1:0]    rs_IdEx,
    input  logic [AW-1:0]        rd_IdEx,
    input  logic [AW-1:0]        rd_ExMem,
    input  logic [AW-1:0]        rd_MemWB,
    input  logic                 reg_write_IdEx,
    input  logic                 reg_write_ExMem,
    input  logic                 reg_write_MemWB,
    input  logic [1:0]           result_src_IdEx,
    input  logic [1:0]           result_src_ExMem,
    input  logic                 mreq_ExMem,
    input  logic                 pc_src_E,
    output logic [NRS*2-1:0]     forward,
    output logic                 en_pc,
    output logic                 en_IfId,
    output logic                 en_IdEx,
    output logic                 en_ExMem,
    output logic                 en_MemWB,
    output logic                 flush_IfId,
    output logic                 flush_IdEx,
    output logic                 flush_ExMem,
    output logic                 mem_done,
    output logic [CNT_W-1:0]     stall_cycles
);

    // Wait-counter width; kept at least one bit so MEM_LAT=0 still elaborates.
    localparam int c_CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [c_CW-1:0] c_LAT_M1 = (MEM_LAT > 0) ? c_CW'(MEM_LAT - 1) : '0;
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;

    localparam logic [1:0] c_FWD_REG = 2'b00;
    localparam logic [1:0] c_FWD_EXM = 2'b01;
    localparam logic [1:0] c_FWD_WB  = 2'b10;

    logic [0:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [CNT_W-1:0] r_stall;

    logic [NRS-1:0] w_exmem_hit;
    logic [NRS-1:0] w_memwb_hit;
    logic [NRS-1:0] w_ld_hit;

    logic w_ex_hold;
    logic w_load_use;
    logic w_branch;
    logic w_mem_wait;
    logic w_mem_done;

    // Per-operand register matching; register x0 never counts as a match.
    genvar gi;
    generate
        for (gi = 0; gi < NRS; gi++) begin : g_op
            logic [AW-1:0] w_rs_ex;
            logic [AW-1:0] w_rs_id;
            assign w_rs_ex = rs_IdEx[gi*AW +: AW];
            assign w_rs_id = rs_IfId[gi*AW +: AW];

            assign w_exmem_hit[gi] = reg_write_ExMem && (rd_ExMem != '0) && (rd_ExMem == w_rs_ex);
            assign w_memwb_hit[gi] = reg_write_MemWB && (rd_MemWB != '0) && (rd_MemWB == w_rs_ex);
            assign w_ld_hit[gi]    = (rd_IdEx != '0) && (rd_IdEx == w_rs_id);

            // ExMem can only forward an ALU result; other result kinds
            // are not ready until WB and trigger ex_hold instead.
            always_comb begin
                forward[gi*2 +: 2] = c_FWD_REG;
                if (rst) begin
                    forward[gi*2 +: 2] = c_FWD_REG;
                end else if (w_exmem_hit[gi] && (result_src_ExMem == c_SRC_ALU)) begin
                    forward[gi*2 +: 2] = c_FWD_EXM;
                end else if (w_memwb_hit[gi]) begin
                    forward[gi*2 +: 2] = c_FWD_WB;
                end
            end
        end
    endgenerate

    assign w_ex_hold  = (result_src_ExMem != c_SRC_ALU) && (|w_exmem_hit);
    assign w_load_use = reg_write_IdEx && (result_src_IdEx == c_SRC_LOAD) && (|w_ld_hit);
    assign w_branch   = pc_src_E;

    // Memory wait: stall while the access is outstanding, release for one
    // cycle once the down-counter has drained.
    always_comb begin
        w_mem_wait = 1'b0;
        w_mem_done = 1'b0;
        if (!rst) begin
            if (r_state == c_IDLE) begin
                if (mreq_ExMem) begin
                    if (MEM_LAT > 0) begin
                        w_mem_wait = 1'b1;
                    end else begin
                        w_mem_done = 1'b1;
                    end
                end
            end else begin
                if (r_cnt != '0) begin
                    w_mem_wait = 1'b1;
                end else begin
                    w_mem_done = 1'b1;
                end
            end
        end
    end

    assign mem_done = w_mem_done;

    // Memory-wait FSM state and down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (mreq_ExMem && (MEM_LAT > 0)) begin
                        r_state <= c_WAIT;
                        r_cnt   <= c_LAT_M1;
                    end
                end
                default: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    // Enables and flushes, resolved by priority:
    // mem_wait > ex_hold > branch > load_use > default.
    always_comb begin
        en_pc       = 1'b1;
        en_IfId     = 1'b1;
        en_IdEx     = 1'b1;
        en_ExMem    = 1'b1;
        en_MemWB    = 1'b1;
        flush_IfId  = 1'b0;
        flush_IdEx  = 1'b0;
        flush_ExMem = 1'b0;
        if (rst) begin
            flush_IfId  = 1'b1;
            flush_IdEx  = 1'b1;
            flush_ExMem = 1'b1;
        end else if (w_mem_wait) begin
            // Freeze everything; MemWB re-writes the same value, harmlessly.
            en_pc    = 1'b0;
            en_IfId  = 1'b0;
            en_IdEx  = 1'b0;
            en_ExMem = 1'b0;
            en_MemWB = 1'b0;
        end else if (w_ex_hold) begin
            // Hold EX one cycle and bubble ExMem; the producer then reaches
            // MemWB and forwards from there. A pending branch waits in EX.
            en_pc       = 1'b0;
            en_IfId     = 1'b0;
            en_IdEx     = 1'b0;
            flush_ExMem = 1'b1;
        end else if (w_branch) begin
            // Target loads into PC; the two younger instructions are killed,
            // which also disposes of any coincident load-use.
            flush_IfId = 1'b1;
            flush_IdEx = 1'b1;
        end else if (w_load_use) begin
            en_pc      = 1'b0;
            en_IfId    = 1'b0;
            flush_IdEx = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (!en_pc && (r_stall != '1)) begin
            r_stall <= r_stall + c_CNT_ONE;
        end
    end

    assign stall_cycles = r_stall;

endmodule
`default_nettype wire
